// File: rtl/life_board_controller.sv
// -----------------------------------------------------------------------------
// life_board_controller
//
// Holds the registered Game of Life board and sequences generations. board_q
// feeds an external combinational algorithm stage; its next_board result is
// latched back on each step. Seed rows are written through a valid/ready
// handshake while the board is not free-running. The block also provides
// run / pause / single-step control and optional halting on a stable board.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load_valid    seed row write request
//   load_ready    row write accepted when load_valid && load_ready (not in RUN)
//   load_row      row index; indices >= ROWS are accepted but not written
//   load_data     row contents, bit c = column c
//   clear         one-cycle pulse: zero board and generation counter
//   run           level: 1 = free-run, 0 = pause
//   step_tick     pacing pulse for RUN
//   single_step   advance one generation while paused (IDLE or HALTED)
//   next_board    next generation from the algorithm stage
//   board_q       current board, cell (r,c) = board_q[r*COLS+c]
//   gen_count     generations since last clear/load, saturating
//   gen_valid     one-cycle pulse while a freshly stepped board is first shown
//   state_q       00 IDLE, 01 RUN, 10 HALTED
//   extinct       board_q is all zero (combinational)
//   stable        next_board == board_q (combinational)
// -----------------------------------------------------------------------------
module life_board_controller #(
  parameter int ROWS           = 16,
  parameter int COLS           = 16,
  parameter int GEN_W          = 16,
  parameter bit STOP_ON_STABLE = 1'b1,
  localparam int RW            = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [RW-1:0]        load_row,
  input  logic [COLS-1:0]      load_data,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 step_tick,
  input  logic                 single_step,
  input  logic [ROWS*COLS-1:0] next_board,
  output logic [ROWS*COLS-1:0] board_q,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 gen_valid,
  output logic [1:0]           state_q,
  output logic                 extinct,
  output logic                 stable
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t                 state_r, state_d;
  logic                   load_fire;
  logic                   do_step;
  logic [ROWS*COLS-1:0]   board_d;
  logic [GEN_W-1:0]       gen_d;

  assign load_ready = (state_r != RUN);
  assign load_fire  = load_valid && load_ready;
  assign extinct    = (board_q == '0);
  assign stable     = (next_board == board_q);
  assign state_q    = state_r;

  // Next-state and step qualification. clear and an accepted row load both
  // take priority over a step in the same cycle, so they veto do_step here.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_r;
    do_step = 1'b0;
    unique case (state_r)
      IDLE: begin
        // Entering RUN takes precedence; nothing steps in the transition cycle.
        if (run) begin
          state_d = RUN;
        end else if (single_step && !clear && !load_fire) begin
          do_step = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
        end else if (step_tick && !clear) begin
          if (STOP_ON_STABLE && stable) begin
            state_d = HALTED;
          end else begin
            do_step = 1'b1;
          end
        end
      end
      HALTED: begin
        // Any edit of the board leaves the halted condition behind.
        if (clear || load_fire || !run) begin
          state_d = IDLE;
        end else if (single_step) begin
          do_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Board and counter update with clear > row load > step priority.
  always_comb begin
    board_d = board_q;
    gen_d   = gen_count;
    if (clear) begin
      board_d = '0;
      gen_d   = '0;
    end else if (load_fire) begin
      // Decoding against each legal row means an out-of-range index simply
      // matches nothing, while the handshake still completes.
      for (int r = 0; r < ROWS; r++) begin
        if (load_row == RW'(r)) begin
          board_d[r*COLS +: COLS] = load_data;
        end
      end
      gen_d = '0;
    end else if (do_step) begin
      board_d = next_board;
      gen_d   = (gen_count == '1) ? gen_count : gen_count + GEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      board_q   <= '0;
      gen_count <= '0;
      gen_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_r   <= state_d;
      board_q   <= board_d;
      gen_count <= gen_d;
      gen_valid <= do_step;
    end
  end

endmodule

// File: tb/tb_life_board_controller.sv
// -----------------------------------------------------------------------------
// tb_life_board_controller
//
// Directed bench for life_board_controller. A toroidal Life function stands in
// for the algorithm stage of the main 16x16 instance. A second, small instance
// (12 rows, 4-bit generation counter) exercises out-of-range row indices and
// counter saturation; its algorithm stage simply inverts the board.
// -----------------------------------------------------------------------------
module tb_life_board_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance signals
  logic         load_valid, load_ready, clear, run, step_tick, single_step;
  logic [3:0]   load_row;
  logic [15:0]  load_data;
  logic [255:0] next_board, board_q;
  logic [15:0]  gen_count;
  logic         gen_valid, extinct, stable;
  logic [1:0]   state_q;

  // Small instance signals
  logic         load_valid2, load_ready2, clear2, run2, step_tick2, single_step2;
  logic [3:0]   load_row2;
  logic [15:0]  load_data2;
  logic [191:0] next_board2, board_q2;
  logic [3:0]   gen_count2;
  logic         gen_valid2, extinct2, stable2;
  logic [1:0]   state_q2;

  int n_cmp = 0;
  int n_err = 0;

  life_board_controller dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_row(load_row), .load_data(load_data),
    .clear(clear), .run(run), .step_tick(step_tick), .single_step(single_step),
    .next_board(next_board), .board_q(board_q), .gen_count(gen_count),
    .gen_valid(gen_valid), .state_q(state_q), .extinct(extinct), .stable(stable)
  );

  life_board_controller #(.ROWS(12), .COLS(16), .GEN_W(4), .STOP_ON_STABLE(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid2), .load_ready(load_ready2),
    .load_row(load_row2), .load_data(load_data2),
    .clear(clear2), .run(run2), .step_tick(step_tick2), .single_step(single_step2),
    .next_board(next_board2), .board_q(board_q2), .gen_count(gen_count2),
    .gen_valid(gen_valid2), .state_q(state_q2), .extinct(extinct2), .stable(stable2)
  );

  // Toroidal 16x16 Life rule: the algorithm stage feeding the main instance.
  function automatic logic [255:0] life_next(input logic [255:0] b);
    logic [255:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0)
              cnt += int'(b[((r + dr + 16) % 16) * 16 + ((c + dc + 16) % 16)]);
          end
        end
        n[r*16+c] = (cnt == 3) || (cnt == 2 && b[r*16+c]);
      end
    end
    return n;
  endfunction

  always_comb next_board  = life_next(board_q);
  always_comb next_board2 = ~board_q2;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load1(input logic [3:0] row, input logic [15:0] data);
    load_valid = 1'b1;
    load_row   = row;
    load_data  = data;
    cyc(1);
    load_valid = 1'b0;
    cyc(1);
  endtask

  task automatic load2(input logic [3:0] row, input logic [15:0] data);
    load_valid2 = 1'b1;
    load_row2   = row;
    load_data2  = data;
    cyc(1);
    load_valid2 = 1'b0;
    cyc(1);
  endtask

  task automatic tick1();
    step_tick = 1'b1;
    cyc(1);
    step_tick = 1'b0;
  endtask

  // Watchdog: the sequence is purely cycle-counted, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] vert, horiz, glider, block, exp_b;
    logic [191:0] board2_snap;
    bit           halted_seen;

    vert  = '0; vert[7*16+8]  = 1'b1; vert[8*16+8]  = 1'b1; vert[9*16+8]  = 1'b1;
    horiz = '0; horiz[8*16+7] = 1'b1; horiz[8*16+8] = 1'b1; horiz[8*16+9] = 1'b1;
    glider = '0;
    glider[0*16 +: 16] = 16'h0002;
    glider[1*16 +: 16] = 16'h0004;
    glider[2*16 +: 16] = 16'h0007;
    block = '0;
    block[4*16 +: 16] = 16'h0018;
    block[5*16 +: 16] = 16'h0018;

    rst_n = 1'b0;
    load_valid = 0; load_row = '0; load_data = '0;
    clear = 0; run = 0; step_tick = 0; single_step = 0;
    load_valid2 = 0; load_row2 = '0; load_data2 = '0;
    clear2 = 0; run2 = 0; step_tick2 = 0; single_step2 = 0;
    #12 rst_n = 1'b1;
    cyc(5);

    // 1. Reset state
    check("reset_board", board_q, '0);
    check("reset_gen", gen_count, '0);
    check("reset_state", state_q, 2'b00);
    check("reset_ready", load_ready, 1'b1);
    check("reset_extinct", extinct, 1'b1);
    check("reset_stable", stable, 1'b1);
    check("reset_gen_valid", gen_valid, 1'b0);

    // 2. Blinker load with gaps, then free-run paced every 4 clocks
    load1(4'd7, 16'h0100);
    load1(4'd8, 16'h0100);
    load1(4'd9, 16'h0100);
    check("blinker_loaded", board_q, vert);
    check("blinker_gen0", gen_count, '0);
    check("blinker_extinct", extinct, 1'b0);
    run = 1'b1;
    cyc(1);
    check("run_state", state_q, 2'b01);
    check("run_ready", load_ready, 1'b0);
    for (int g = 1; g <= 3; g++) begin
      exp_b = (g % 2 == 1) ? horiz : vert;
      tick1();
      check($sformatf("blinker_board_g%0d", g), board_q, exp_b);
      check($sformatf("blinker_gen_g%0d", g), gen_count, 16'(g));
      check($sformatf("blinker_gvalid_g%0d", g), gen_valid, 1'b1);
      cyc(1);
      check($sformatf("blinker_gvalid_drop_g%0d", g), gen_valid, 1'b0);
      cyc(2);
    end

    // 3. Glider on the torus: 64 generations bring it back to its start
    run = 1'b0;
    cyc(1);
    check("pause_state", state_q, 2'b00);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_board", board_q, '0);
    check("clear_gen", gen_count, '0);
    load1(4'd0, 16'h0002);
    load1(4'd1, 16'h0004);
    load1(4'd2, 16'h0007);
    check("glider_loaded", board_q, glider);
    run = 1'b1;
    cyc(1);
    halted_seen = 1'b0;
    for (int t = 0; t < 64; t++) begin
      tick1();
      if (state_q == 2'b10) halted_seen = 1'b1;
      cyc(3);
    end
    check("glider_board", board_q, glider);
    check("glider_gen", gen_count, 16'd64);
    check("glider_never_halted", halted_seen, 1'b0);
    check("glider_state", state_q, 2'b01);

    // 4. Block still-life halts on the first tick
    run = 1'b0;
    cyc(1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    load1(4'd4, 16'h0018);
    load1(4'd5, 16'h0018);
    check("block_stable", stable, 1'b1);
    run = 1'b1;
    cyc(1);
    tick1();
    check("block_halt_state", state_q, 2'b10);
    check("block_halt_gen", gen_count, '0);
    check("block_halt_gvalid", gen_valid, 1'b0);
    check("halted_ready", load_ready, 1'b1);
    single_step = 1'b1;
    cyc(1);
    single_step = 1'b0;
    check("halted_step_gen", gen_count, 16'd1);
    check("halted_step_gvalid", gen_valid, 1'b1);
    check("halted_step_state", state_q, 2'b10);
    check("halted_step_board", board_q, block);
    run = 1'b0;
    cyc(1);
    check("halted_to_idle", state_q, 2'b00);

    // 5. Simultaneous events
    load_valid  = 1'b1;
    load_row    = 4'd0;
    load_data   = 16'hFFFF;
    single_step = 1'b1;
    cyc(1);
    load_valid  = 1'b0;
    single_step = 1'b0;
    exp_b = block;
    exp_b[0 +: 16] = 16'hFFFF;
    check("load_vs_step_board", board_q, exp_b);
    check("load_vs_step_gen", gen_count, '0);
    check("load_vs_step_gvalid", gen_valid, 1'b0);
    run = 1'b1;
    cyc(1);
    load_valid = 1'b1;
    load_row   = 4'd3;
    load_data  = 16'hFFFF;
    cyc(1);
    load_valid = 1'b0;
    check("run_load_blocked", board_q, exp_b);
    clear     = 1'b1;
    step_tick = 1'b1;
    cyc(1);
    clear     = 1'b0;
    step_tick = 1'b0;
    check("clear_vs_tick_board", board_q, '0);
    check("clear_vs_tick_gen", gen_count, '0);
    check("clear_vs_tick_gvalid", gen_valid, 1'b0);
    check("clear_vs_tick_state", state_q, 2'b01);
    run = 1'b0;
    cyc(1);

    // Out-of-range row on the 12-row instance: accepted, not written
    load2(4'd11, 16'hFFFF);
    board2_snap = board_q2;
    check("small_row11", board_q2[11*16 +: 16], 16'hFFFF);
    load_valid2 = 1'b1;
    load_row2   = 4'd13;
    load_data2  = 16'hA5A5;
    #1;
    check("oor_ready", load_ready2, 1'b1);
    cyc(1);
    load_valid2 = 1'b0;
    check("oor_no_write", board_q2, board2_snap);

    // 6. Counter saturation: 20 single steps on a 4-bit counter
    single_step2 = 1'b1;
    cyc(14);
    check("sat_gen14", gen_count2, 4'hE);
    cyc(6);
    single_step2 = 1'b0;
    check("sat_gen20", gen_count2, 4'hF);
    check("sat_board", board_q2, board2_snap);

    // Asynchronous reset in the middle of a run, away from any clock edge
    load1(4'd0, 16'h0002);
    load1(4'd1, 16'h0004);
    load1(4'd2, 16'h0007);
    run = 1'b1;
    cyc(1);
    tick1();
    check("pre_reset_gen", gen_count, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_board", board_q, '0);
    check("async_gen", gen_count, '0);
    check("async_state", state_q, 2'b00);
    check("async_gvalid", gen_valid, 1'b0);
    check("async_gen2", gen_count2, 4'h0);
    check("async_board2", board_q2, '0);
    run = 1'b0;
    #10 rst_n = 1'b1;
    cyc(2);
    check("post_reset_ready", load_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
